ctrl_pipeline_chain: RTL and testbench

CTRL_PIPELINE_CHAIN -- requirements
Module: ctrl_pipeline_chain

---
 rtl/ctrl_pipeline_chain.sv | 126 ++++++++++++
 tb/tb_ctrl_pipeline_chain.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipeline_chain.sv
// Control-word pipeline from decode through WB with per-stage stall, hazard
// bubble insertion, ranged flush and saturating stall/bubble statistics.
`timescale 1ns/1ps
module ctrl_pipeline_chain #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 3,
    parameter int IDXW   = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          ctrl_in,
    input  logic                      ctrl_valid_in,
    input  logic                      hazard,
    input  logic [STAGES-1:0]         stall,
    input  logic                      flush,
    input  logic [IDXW-1:0]           flush_upto,
    output logic [STAGES*WIDTH-1:0]   ctrl_out,
    output logic [STAGES-1:0]         valid_out,
    output logic                      accept,
    output logic                      retire,
    output logic [IDXW:0]             in_flight,
    output logic [15:0]               stall_count,
    output logic [15:0]               bubble_count
);

    logic [WIDTH-1:0]  word_q [STAGES];
    logic [WIDTH-1:0]  word_d [STAGES];
    logic [STAGES-1:0] valid_q, valid_d;
    logic [IDXW:0]     in_flight_q, in_flight_d;
    logic [15:0]       stall_count_q, stall_count_d;
    logic [15:0]       bubble_count_q, bubble_count_d;
    logic [STAGES-1:0] hold;
    logic              bubble_inc;

    // A stage holds whenever it or any younger-numbered-later stage is stalled,
    // i.e. its index is at or below the highest stalled stage.
    always_comb begin
        hold = '0;
        for (int k = 0; k < STAGES; k++) begin
            hold[k] = |(stall >> k);
        end
    end

    always_comb begin
        accept     = ~|stall;
        retire     = valid_q[STAGES-1] & ~stall[STAGES-1];
        bubble_inc = accept & hazard & ~flush;

        for (int k = 0; k < STAGES; k++) begin
            word_d[k] = word_q[k];
        end
        valid_d = valid_q;

        if (flush) begin
            word_d[0]  = '0;
            valid_d[0] = 1'b0;
        end else if (!hold[0]) begin
            word_d[0]  = hazard ? '0 : ctrl_in;
            valid_d[0] = hazard ? 1'b0 : ctrl_valid_in;
        end

        // Flush overrides everything; the stage just above a held region
        // receives a bubble so held instructions are not duplicated.
        for (int k = 1; k < STAGES; k++) begin
            if (flush && (k <= int'(flush_upto))) begin
                word_d[k]  = '0;
                valid_d[k] = 1'b0;
            end else if (hold[k]) begin
                word_d[k]  = word_q[k];
                valid_d[k] = valid_q[k];
            end else if (hold[k-1]) begin
                word_d[k]  = '0;
                valid_d[k] = 1'b0;
            end else begin
                word_d[k]  = word_q[k-1];
                valid_d[k] = valid_q[k-1];
            end
        end

        in_flight_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            in_flight_d = in_flight_d + {{IDXW{1'b0}}, valid_d[k]};
        end

        stall_count_d  = stall_count_q;
        bubble_count_d = bubble_count_q;
        if (!accept && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
        if (bubble_inc && (bubble_count_q != 16'hFFFF)) begin
            bubble_count_d = bubble_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                word_q[k] <= '0;
            end
            valid_q        <= '0;
            in_flight_q    <= '0;
            stall_count_q  <= '0;
            bubble_count_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                word_q[k] <= word_d[k];
            end
            valid_q        <= valid_d;
            in_flight_q    <= in_flight_d;
            stall_count_q  <= stall_count_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            ctrl_out[k*WIDTH +: WIDTH] = word_q[k];
        end
    end

    assign valid_out    = valid_q;
    assign in_flight    = in_flight_q;
    assign stall_count  = stall_count_q;
    assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_ctrl_pipeline_chain.sv
// Directed bench for ctrl_pipeline_chain (WIDTH=8, STAGES=3): streaming,
// hazard bubbles, stalls, flushes, async reset and counter saturation.
`timescale 1ns/1ps
module tb_ctrl_pipeline_chain;

    localparam int WIDTH  = 8;
    localparam int STAGES = 3;
    localparam int IDXW   = 3;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [WIDTH-1:0]        ctrlIn;
    logic                    ctrlValidIn;
    logic                    hazard;
    logic [STAGES-1:0]       stall;
    logic                    flush;
    logic [IDXW-1:0]         flushUpto;
    logic [STAGES*WIDTH-1:0] ctrlOut;
    logic [STAGES-1:0]       validOut;
    logic                    accept;
    logic                    retire;
    logic [IDXW:0]           inFlight;
    logic [15:0]             stallCount;
    logic [15:0]             bubbleCount;

    int vectors = 0;
    int miscompares = 0;

    ctrl_pipeline_chain #(.WIDTH(WIDTH), .STAGES(STAGES), .IDXW(IDXW)) dut (
        .clk          (clk),
        .reset        (reset),
        .ctrl_in      (ctrlIn),
        .ctrl_valid_in(ctrlValidIn),
        .hazard       (hazard),
        .stall        (stall),
        .flush        (flush),
        .flush_upto   (flushUpto),
        .ctrl_out     (ctrlOut),
        .valid_out    (validOut),
        .accept       (accept),
        .retire       (retire),
        .in_flight    (inFlight),
        .stall_count  (stallCount),
        .bubble_count (bubbleCount)
    );

    always #5 clk = ~clk;

    // Inputs change shortly after a rising edge and settle before sampling.
    task automatic applyStimulus(input logic [WIDTH-1:0] c, input logic v, input logic h,
                                 input logic [STAGES-1:0] s, input logic f,
                                 input logic [IDXW-1:0] u);
        ctrlIn      = c;
        ctrlValidIn = v;
        hazard      = h;
        stall       = s;
        flush       = f;
        flushUpto   = u;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkPipe(input string tag, input logic [23:0] expWord,
                             input logic [2:0] expValid, input logic [3:0] expFlight);
        checkOutput({tag, "_ctrl"}, 64'(ctrlOut), 64'(expWord));
        checkOutput({tag, "_valid"}, 64'(validOut), 64'(expValid));
        checkOutput({tag, "_inflight"}, 64'(inFlight), 64'(expFlight));
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(8'h00, 1'b0, 1'b0, 3'b000, 1'b0, 3'd0);
        checkPipe("reset", 24'h000000, 3'b000, 4'd0);
        checkOutput("reset_stallcnt", 64'(stallCount), 64'd0);
        checkOutput("reset_bubblecnt", 64'(bubbleCount), 64'd0);
        checkOutput("reset_retire", 64'(retire), 64'd0);

        // Held in reset across an edge with a valid word on the input.
        applyStimulus(8'h5A, 1'b1, 1'b0, 3'b000, 1'b0, 3'd0);
        tick();
        checkPipe("reset_hold", 24'h000000, 3'b000, 4'd0);
        reset = 1'b0;

        // Streaming 0x11, 0x22, 0x33 then drain.
        applyStimulus(8'h11, 1'b1, 1'b0, 3'b000, 1'b0, 3'd0);
        tick();
        checkPipe("stream_e1", 24'h000011, 3'b001, 4'd1);
        applyStimulus(8'h22, 1'b1, 1'b0, 3'b000, 1'b0, 3'd0);
        tick();
        checkPipe("stream_e2", 24'h001122, 3'b011, 4'd2);
        checkOutput("stream_e2_retire", 64'(retire), 64'd0);
        applyStimulus(8'h33, 1'b1, 1'b0, 3'b000, 1'b0, 3'd0);
        tick();
        checkPipe("stream_e3", 24'h112233, 3'b111, 4'd3);
        checkOutput("stream_e3_retire", 64'(retire), 64'd1);
        checkOutput("stream_accept", 64'(accept), 64'd1);
        applyStimulus(8'h00, 1'b0, 1'b0, 3'b000, 1'b0, 3'd0);
        tick();
        checkPipe("stream_e4", 24'h223300, 3'b110, 4'd2);
        checkOutput("stream_e4_retire", 64'(retire), 64'd1);
        tick();
        checkPipe("stream_e5", 24'h330000, 3'b100, 4'd1);
        checkOutput("stream_e5_retire", 64'(retire), 64'd1);
        tick();
        checkPipe("stream_e6", 24'h000000, 3'b000, 4'd0);
        checkOutput("stream_e6_retire", 64'(retire), 64'd0);

        // Hazard bubble between 0x11 and 0x22; ctrl_in ignored while hazard.
        pulseReset();
        applyStimulus(8'h11, 1'b1, 1'b0, 3'b000, 1'b0, 3'd0);
        tick();
        applyStimulus(8'h22, 1'b1, 1'b1, 3'b000, 1'b0, 3'd0);
        tick();
        checkPipe("hazard_e2", 24'h001100, 3'b010, 4'd1);
        checkOutput("hazard_bubblecnt", 64'(bubbleCount), 64'd1);
        applyStimulus(8'h22, 1'b1, 1'b0, 3'b000, 1'b0, 3'd0);
        tick();
        checkPipe("hazard_e3", 24'h110022, 3'b101, 4'd2);
        applyStimulus(8'h00, 1'b0, 1'b0, 3'b000, 1'b0, 3'd0);
        tick();
        checkOutput("hazard_e4_retire", 64'(retire), 64'd0);
        tick();
        checkPipe("hazard_e5", 24'h220000, 3'b100, 4'd1);
        checkOutput("hazard_e5_retire", 64'(retire), 64'd1);
        checkOutput("hazard_bubblecnt_end", 64'(bubbleCount), 64'd1);

        // Stall on stage 0 for two cycles with a full pipeline.
        pulseReset();
        applyStimulus(8'h11, 1'b1, 1'b0, 3'b000, 1'b0, 3'd0);
        tick();
        applyStimulus(8'h22, 1'b1, 1'b0, 3'b000, 1'b0, 3'd0);
        tick();
        applyStimulus(8'h33, 1'b1, 1'b0, 3'b000, 1'b0, 3'd0);
        tick();
        applyStimulus(8'h44, 1'b1, 1'b1, 3'b001, 1'b0, 3'd0);
        checkOutput("stall_accept", 64'(accept), 64'd0);
        tick();
        checkPipe("stall_e4", 24'h220033, 3'b101, 4'd2);
        checkOutput("stall_cnt1", 64'(stallCount), 64'd1);
        tick();
        checkPipe("stall_e5", 24'h000033, 3'b001, 4'd1);
        checkOutput("stall_cnt2", 64'(stallCount), 64'd2);
        checkOutput("stall_nobubble", 64'(bubbleCount), 64'd0);
        applyStimulus(8'h44, 1'b1, 1'b0, 3'b000, 1'b0, 3'd0);
        checkOutput("stall_release_accept", 64'(accept), 64'd1);
        tick();
        checkPipe("stall_e6", 24'h003344, 3'b011, 4'd2);
        checkOutput("stall_cnt_hold", 64'(stallCount), 64'd2);

        // Ranged flush of stages 0..1 together with a stage-0 stall.
        pulseReset();
        applyStimulus(8'h11, 1'b1, 1'b0, 3'b000, 1'b0, 3'd0);
        tick();
        applyStimulus(8'h22, 1'b1, 1'b0, 3'b000, 1'b0, 3'd0);
        tick();
        applyStimulus(8'h33, 1'b1, 1'b0, 3'b000, 1'b0, 3'd0);
        tick();
        applyStimulus(8'h44, 1'b1, 1'b0, 3'b001, 1'b1, 3'd1);
        checkOutput("flush_pre_retire", 64'(retire), 64'd1);
        tick();
        checkPipe("flush_e4", 24'h220000, 3'b100, 4'd1);
        applyStimulus(8'h55, 1'b1, 1'b0, 3'b000, 1'b0, 3'd0);
        tick();
        applyStimulus(8'h66, 1'b1, 1'b0, 3'b000, 1'b0, 3'd0);
        tick();
        applyStimulus(8'h77, 1'b1, 1'b0, 3'b000, 1'b0, 3'd0);
        tick();
        checkPipe("flush_refill", 24'h556677, 3'b111, 4'd3);
        applyStimulus(8'h88, 1'b1, 1'b0, 3'b100, 1'b0, 3'd0);
        checkOutput("wb_stall_retire", 64'(retire), 64'd0);
        tick();
        checkPipe("wb_stall_hold", 24'h556677, 3'b111, 4'd3);
        applyStimulus(8'h88, 1'b1, 1'b1, 3'b000, 1'b1, 3'd7);
        checkOutput("flushall_pre_retire", 64'(retire), 64'd1);
        tick();
        checkPipe("flushall", 24'h000000, 3'b000, 4'd0);
        checkOutput("flushall_bubblecnt", 64'(bubbleCount), 64'd0);
        checkOutput("flushall_stallcnt", 64'(stallCount), 64'd2);

        // Asynchronous reset between edges with a full pipeline.
        applyStimulus(8'hA1, 1'b1, 1'b0, 3'b000, 1'b0, 3'd0);
        tick();
        applyStimulus(8'hA2, 1'b1, 1'b1, 3'b000, 1'b0, 3'd0);
        tick();
        applyStimulus(8'hA3, 1'b1, 1'b0, 3'b000, 1'b0, 3'd0);
        tick();
        checkPipe("areset_pre", 24'hA100A3, 3'b101, 4'd2);
        reset = 1'b1;
        #1;
        checkPipe("areset", 24'h000000, 3'b000, 4'd0);
        checkOutput("areset_retire", 64'(retire), 64'd0);
        checkOutput("areset_stallcnt", 64'(stallCount), 64'd0);
        checkOutput("areset_bubblecnt", 64'(bubbleCount), 64'd0);
        reset = 1'b0;
        applyStimulus(8'h00, 1'b0, 1'b0, 3'b000, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("post_reset_retire", 64'(retire), 64'd0);
        end

        // Stall counter saturation.
        applyStimulus(8'h00, 1'b0, 1'b0, 3'b001, 1'b0, 3'd0);
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
        end
        #1;
        checkOutput("stallcnt_sat", 64'(stallCount), 64'hFFFF);
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        checkOutput("stallcnt_sat_stays", 64'(stallCount), 64'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
